// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter owning the register-file write port through a
//            registered stage. Optional post-reset clear sweep of regs 1..31
//            compiled in with REGFILE_ARB_CLEAR_EN.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rf_reg_write,
    output logic [ADDR_W-1:0]      rf_write_addr,
    output logic [DATA_W-1:0]      rf_write_data,
    output logic [1:0]             grant_id,
    output logic                   busy
);

    localparam logic [1:0] c_LAST_RST = 2'(NREQ - 1);

    logic [ADDR_W-1:0] w_addr [NREQ];
    logic [DATA_W-1:0] w_data [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic              w_run;
    logic              w_clearing;
    logic [ADDR_W-1:0] w_clr_addr;

`ifdef REGFILE_ARB_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_CLR_LAST = ADDR_W'(31);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= ADDR_W'(1);
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clearing    = 1'b0;
        w_run         = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing    = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == c_CLR_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_run = 1'b1;
            end
        endcase
    end

    assign w_clr_addr = r_clr_cnt;
    assign busy       = ~w_run;
`else
    assign w_run      = 1'b1;
    assign w_clearing = 1'b0;
    assign w_clr_addr = '0;
    assign busy       = 1'b0;
`endif

    // Round-robin search starting just after the last accepted requester.
    logic [1:0]      r_last;
    logic [NREQ-1:0] w_grant;
    logic [1:0]      w_gnt_idx;
    logic [1:0]      w_idx;
    logic            w_found;
    int              w_sum;

    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_idx     = '0;
        w_found   = 1'b0;
        w_sum     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = int'(r_last) + k;
            w_idx = (w_sum >= NREQ) ? 2'(w_sum - NREQ) : 2'(w_sum);
            if (!w_found && req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gnt_idx      = w_idx;
            end
        end
    end

    assign req_ready = (rst_n && w_run) ? w_grant : '0;

    logic w_accept;
    assign w_accept = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write  <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            grant_id      <= '0;
            r_last        <= c_LAST_RST;
        end else if (w_clearing) begin
            rf_reg_write  <= 1'b1;
            rf_write_addr <= w_clr_addr;
            rf_write_data <= '0;
        end else if (w_accept) begin
            // A write to $zero completes the handshake but never reaches the file.
            rf_reg_write  <= (w_addr[w_gnt_idx] != '0);
            rf_write_addr <= w_addr[w_gnt_idx];
            rf_write_data <= w_data[w_gnt_idx];
            grant_id      <= w_gnt_idx;
            r_last        <= w_gnt_idx;
        end else begin
            rf_reg_write  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench: vector table, corner sequences, random run
//            against a round-robin reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        tb_clk = 1'b0;
    logic        rst_n  = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr  = '0;
    logic [95:0] req_data  = '0;
    logic [2:0]  req_ready;
    logic        rf_reg_write;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [1:0]  grant_id;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 tb_clk = ~tb_clk;

    regfile_write_arbiter #(.NREQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clk           (tb_clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_reg_write  (rf_reg_write),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    // Register file fed by the write port; starts with non-zero garbage.
    logic [31:0] rf_mem [32];
    bit          mem_init = 1'b0;
    always @(posedge tb_clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hBAD0_0000 | 32'(i);
            mem_init <= 1'b1;
        end else if (rf_reg_write && rf_write_addr != 5'd0) begin
            rf_mem[rf_write_addr] <= rf_write_data;
        end
    end

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  gid;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic step(input vec_t t);
        drive(t.v, t.a0, t.a1, t.a2, t.d0, t.d1, t.d2);
        #1;
        chk("req_ready", req_ready, t.ready);
        @(posedge tb_clk); #1;
        chk("rf_reg_write", rf_reg_write, t.we);
        chk("rf_write_addr", rf_write_addr, t.addr);
        chk("rf_write_data", rf_write_data, t.data);
        chk("grant_id", grant_id, t.gid);
    endtask

`ifdef REGFILE_ARB_CLEAR_EN
    task automatic sweep_check(input int n);
        for (int i = 0; i < n; i++) begin
            drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
            #1;
            chk("sweep_busy", busy, 1);
            chk("sweep_ready", req_ready, 0);
            req_valid = '0;
            @(posedge tb_clk); #1;
            chk("sweep_we", rf_reg_write, 1);
            chk("sweep_addr", rf_write_addr, 64'(i + 1));
            chk("sweep_data", rf_write_data, 0);
        end
    endtask
`endif

    task automatic release_and_settle();
        rst_n     = 1'b1;
        req_valid = '0;
`ifdef REGFILE_ARB_CLEAR_EN
        sweep_check(31);
`endif
        chk("busy_run", busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
        #1;
        chk("rst_we", rf_reg_write, 0);
        chk("rst_addr", rf_write_addr, 0);
        chk("rst_data", rf_write_data, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_ready", req_ready, 0);
`ifdef REGFILE_ARB_CLEAR_EN
        chk("rst_busy", busy, 1);
`else
        chk("rst_busy", busy, 0);
`endif
        @(posedge tb_clk); @(posedge tb_clk); #1;
        chk("rst_hold_we", rf_reg_write, 0);
        release_and_settle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [2:0]  pv;
        logic [4:0]  pa [3];
        logic [31:0] pd [3];
        int          m_last;
        int          g;
        int          j;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_gid;

        // {v, a0,a1,a2, d0,d1,d2, ready, we, addr, data, gid}
        for (int r = 0; r < 2; r++) begin
            tbl.push_back('{3'b111, 5'd10, 5'd11, 5'd12, 32'hCAFECAFE, 32'h11111111, 32'h22222222, 3'b001, 1'b1, 5'd10, 32'hCAFECAFE, 2'd0});
            tbl.push_back('{3'b111, 5'd10, 5'd11, 5'd12, 32'hCAFECAFE, 32'h11111111, 32'h22222222, 3'b010, 1'b1, 5'd11, 32'h11111111, 2'd1});
            tbl.push_back('{3'b111, 5'd10, 5'd11, 5'd12, 32'hCAFECAFE, 32'h11111111, 32'h22222222, 3'b100, 1'b1, 5'd12, 32'h22222222, 2'd2});
        end
        tbl.push_back('{3'b010, 5'd17, 5'd5, 5'd17, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h5A5A5A5A, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1});
        tbl.push_back('{3'b000, 5'd17, 5'd18, 5'd19, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1});
        tbl.push_back('{3'b001, 5'd0, 5'd17, 5'd17, 32'h12345678, 32'h5A5A5A5A, 32'h5A5A5A5A, 3'b001, 1'b0, 5'd0, 32'h12345678, 2'd0});
        tbl.push_back('{3'b110, 5'd17, 5'd20, 5'd21, 32'h5A5A5A5A, 32'h10000001, 32'h20000002, 3'b010, 1'b1, 5'd20, 32'h10000001, 2'd1});
        tbl.push_back('{3'b101, 5'd22, 5'd17, 5'd23, 32'h30000003, 32'h5A5A5A5A, 32'h40000004, 3'b100, 1'b1, 5'd23, 32'h40000004, 2'd2});
        tbl.push_back('{3'b101, 5'd22, 5'd17, 5'd23, 32'h30000003, 32'h5A5A5A5A, 32'h40000004, 3'b001, 1'b1, 5'd22, 32'h30000003, 2'd0});
        for (int k = 1; k <= 4; k++) begin
            tbl.push_back('{3'b100, 5'd17, 5'd18, 5'(k), 32'h5A5A5A5A, 32'h5A5A5A5A, 32'hA0000000 | 32'(k),
                            3'b100, 1'b1, 5'(k), 32'hA0000000 | 32'(k), 2'd2});
        end
        tbl.push_back('{3'b000, 5'd17, 5'd18, 5'd19, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 3'b000, 1'b0, 5'd4, 32'hA0000004, 2'd2});

        #2;
        do_reset();
`ifdef REGFILE_ARB_CLEAR_EN
        chk("rf5_cleared", rf_mem[5], 0);
`endif

        foreach (tbl[i]) step(tbl[i]);

        chk("rf5_value", rf_mem[5], 32'hDEADBEEF);
        chk("rf12_value", rf_mem[12], 32'h22222222);
        chk("rf22_value", rf_mem[22], 32'h30000003);
        chk("rf4_value", rf_mem[4], 32'hA0000004);

        // Write latency: visible in the file only after the port cycle.
        step('{3'b010, 5'd17, 5'd6, 5'd17, 32'h5A5A5A5A, 32'h600DF00D, 32'h5A5A5A5A, 3'b010, 1'b1, 5'd6, 32'h600DF00D, 2'd1});
        chk("rf6_not_yet", 64'(rf_mem[6] == 32'h600DF00D), 0);
        step('{3'b000, 5'd17, 5'd18, 5'd19, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 3'b000, 1'b0, 5'd6, 32'h600DF00D, 2'd1});
        chk("rf6_written", rf_mem[6], 32'h600DF00D);

        // Reset with a write in flight: the write must be discarded.
        drive(3'b100, 5'd17, 5'd18, 5'd9, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h99999999);
        #1;
        chk("inflight_ready", req_ready, 3'b100);
        @(posedge tb_clk); #1;
        chk("inflight_we", rf_reg_write, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_we", rf_reg_write, 0);
        chk("midrst_addr", rf_write_addr, 0);
        chk("midrst_data", rf_write_data, 0);
        chk("midrst_gid", grant_id, 0);
        chk("midrst_ready", req_ready, 0);
        @(posedge tb_clk); #1;
        chk("rf9_discarded", 64'(rf_mem[9] == 32'h99999999), 0);
        release_and_settle();

`ifdef REGFILE_ARB_CLEAR_EN
        // Reset in the middle of a sweep restarts it from address 1.
        rst_n = 1'b0;
        #1;
        @(posedge tb_clk); #1;
        rst_n = 1'b1;
        sweep_check(10);
        rst_n = 1'b0;
        #1;
        chk("midsweep_we", rf_reg_write, 0);
        chk("midsweep_addr", rf_write_addr, 0);
        chk("midsweep_busy", busy, 1);
        @(posedge tb_clk); #1;
        release_and_settle();
        exp_addr = 5'd31;
`else
        exp_addr = 5'd0;
`endif

        // Randomized traffic against a round-robin reference model.
        m_last   = 2;
        pv       = '0;
        exp_data = '0;
        exp_gid  = '0;
        for (int i = 0; i < 3; i++) begin
            pa[i] = '0;
            pd[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1'b1;
                    pa[i] = 5'($urandom_range(0, 31));
                    pd[i] = $urandom;
                end
            end
            drive(pv, pa[0], pa[1], pa[2], pd[0], pd[1], pd[2]);
            g = -1;
            for (int k = 1; k <= 3; k++) begin
                j = (m_last + k) % 3;
                if (g < 0 && pv[j]) g = j;
            end
            exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
            #1;
            chk("rnd_ready", req_ready, exp_ready);
            @(posedge tb_clk); #1;
            if (g >= 0) begin
                exp_we   = (pa[g] != 5'd0);
                exp_addr = pa[g];
                exp_data = pd[g];
                exp_gid  = 2'(g);
                m_last   = g;
                pv[g]    = 1'b0;
            end else begin
                exp_we = 1'b0;
            end
            chk("rnd_we", rf_reg_write, exp_we);
            chk("rnd_addr", rf_write_addr, exp_addr);
            chk("rnd_data", rf_write_data, exp_data);
            chk("rnd_gid", grant_id, exp_gid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
